dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory (data_mem) between the single-cycle core's load/store path and
//  an auxiliary requester (program loader / debug port). Decides ownership every cycle, muxes

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_port_arbiter_if.sv | 48 ++++
 rtl/dmem_arb_starve_cnt.sv | 31 +++
 rtl/dmem_port_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// State encoding records last-cycle owner; owner codes name who drives memory now.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_AUX  = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_AUX  = 2'd2
    } owner_t;

    localparam int unsigned MAX_BURST_DEF = 4;

    function automatic int unsigned cnt_w(input int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of core, aux and data_mem signals around the arbiter.
// master: requesters plus memory read data; slave: the arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);

    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic [DW-1:0] core_rdata;
    logic          core_stall;

    logic          aux_req;
    logic          aux_we;
    logic          aux_lock;
    logic [AW-1:0] aux_addr;
    logic [DW-1:0] aux_wdata;
    logic          aux_gnt;
    logic          aux_rvalid;
    logic [DW-1:0] aux_rdata;

    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rdata, core_stall,
        output aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        input  aux_gnt, aux_rvalid, aux_rdata,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rdata, core_stall,
        input  aux_req, aux_we, aux_lock, aux_addr, aux_wdata,
        output aux_gnt, aux_rvalid, aux_rdata,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of core grants handed out while aux is waiting.
// sat tells the arbiter to hand the next contested cycle to aux.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX = MAX_BURST_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned W = cnt_w(MAX);

    logic [W-1:0] cnt;

    assign sat = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares data_mem between the core load/store path and the aux loader/debug port.
// Grant and mux are combinational; owner FSM, starvation count and aux read data registered.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  bus
);

    state_t state;
    state_t state_nxt;
    owner_t owner;
    logic   starve_sat;
    logic   cnt_inc;
    logic   cnt_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset forces no owner so nothing reaches memory while it is held.
    always_comb begin
        owner = OWN_NONE;
        if (reset) begin
            owner = OWN_NONE;
        end else if (state == ST_LOCK) begin
            if (bus.aux_req) begin
                owner = OWN_AUX;
            end
        end else if (bus.core_req && bus.aux_req) begin
            owner = starve_sat ? OWN_AUX : OWN_CORE;
        end else if (bus.core_req) begin
            owner = OWN_CORE;
        end else if (bus.aux_req) begin
            owner = OWN_AUX;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        unique case (owner)
            OWN_AUX: begin
                state_nxt = bus.aux_lock ? ST_LOCK : ST_AUX;
            end
            OWN_CORE: begin
                state_nxt = ST_CORE;
            end
            default: begin
                state_nxt = (state == ST_LOCK) ? ST_LOCK : ST_IDLE;
            end
        endcase
    end

    assign bus.core_gnt   = (owner == OWN_CORE);
    assign bus.aux_gnt    = (owner == OWN_AUX);
    assign bus.core_stall = bus.core_req && !bus.core_gnt && !reset;
    assign bus.core_rdata = bus.mem_rd;

    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_a  = bus.core_addr;
        bus.mem_wd = '0;
        unique case (owner)
            OWN_CORE: begin
                bus.mem_we = bus.core_we;
                bus.mem_a  = bus.core_addr;
                bus.mem_wd = bus.core_wdata;
            end
            OWN_AUX: begin
                bus.mem_we = bus.aux_we;
                bus.mem_a  = bus.aux_addr;
                bus.mem_wd = bus.aux_wdata;
            end
            default: begin
                bus.mem_we = 1'b0;
            end
        endcase
    end

    assign cnt_inc = bus.core_gnt && bus.aux_req;
    assign cnt_clr = bus.aux_gnt || !bus.aux_req;

    dmem_arb_starve_cnt #(
        .MAX (MAX_BURST)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .sat   (starve_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.aux_rvalid <= 1'b0;
            bus.aux_rdata  <= '0;
        end else begin
            bus.aux_rvalid <= bus.aux_gnt && !bus.aux_we;
            if (bus.aux_gnt && !bus.aux_we) begin
                bus.aux_rdata <= bus.mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a small behavioural data_mem.
// Read results are queued when granted and popped when the DUT returns them.
module tb_dmem_port_arbiter;

    logic clk;
    logic reset;

    logic [31:0] mem [64];
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;

    int n_cmp;
    int n_err;

    dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_port_arbiter #(
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_rd = mem[bus.mem_a[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_a[7:2]] <= bus.mem_wd;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.core_req   = 1'b0;
        bus.core_we    = 1'b0;
        bus.core_addr  = '0;
        bus.core_wdata = '0;
        bus.aux_req    = 1'b0;
        bus.aux_we     = 1'b0;
        bus.aux_lock   = 1'b0;
        bus.aux_addr   = '0;
        bus.aux_wdata  = '0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        bus.core_req   = 1'b1;
        bus.core_we    = 1'b1;
        bus.core_addr  = 32'h0000_0004;
        bus.core_wdata = 32'hBAD0_0001;
        bus.aux_req    = 1'b1;
        bus.aux_we     = 1'b1;
        bus.aux_addr   = 32'h0000_0008;
        bus.aux_wdata  = 32'hBAD0_0002;
        step();
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++;
            if (bus.mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we);
            end
            n_cmp++;
            if (bus.core_gnt !== 1'b0 || bus.aux_gnt !== 1'b0) begin
                n_err++;
                $display("FAIL rst_gnt got=%b%b exp=00",
                         bus.core_gnt, bus.aux_gnt);
            end
            n_cmp++;
            if (bus.core_stall !== 1'b0) begin
                n_err++;
                $display("FAIL rst_stall got=%b exp=0", bus.core_stall);
            end
            n_cmp++;
            if (bus.aux_rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL rst_rvalid got=%b exp=0", bus.aux_rvalid);
            end
            step();
        end
        n_cmp++;
        if (mem[1] !== 32'h0 || mem[2] !== 32'h0) begin
            n_err++;
            $display("FAIL rst_nowrite got=%h/%h exp=0", mem[1], mem[2]);
        end
        reset = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_core_only();
        mem[4]        = 32'hDEAD_BEEF;
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h0000_0010;
        exp_q.push_back(32'hDEAD_BEEF);
        settle();
        n_cmp++;
        if (bus.core_gnt !== 1'b1 || bus.core_stall !== 1'b0) begin
            n_err++;
            $display("FAIL core_gnt got=%b stall=%b exp=1/0",
                     bus.core_gnt, bus.core_stall);
        end
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (bus.core_rdata !== exp_v) begin
            n_err++;
            $display("FAIL core_rdata got=%h exp=%h", bus.core_rdata, exp_v);
        end
        step();
        bus.core_we    = 1'b1;
        bus.core_addr  = 32'h0000_0014;
        bus.core_wdata = 32'hC0DE_0005;
        step();
        idle_inputs();
        n_cmp++;
        if (mem[5] !== 32'hC0DE_0005) begin
            n_err++;
            $display("FAIL core_write got=%h exp=c0de0005", mem[5]);
        end
        step();
    endtask

    task automatic test_starvation();
        logic ea;
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h0000_0010;
        bus.aux_req   = 1'b1;
        bus.aux_we    = 1'b1;
        bus.aux_addr  = 32'h0000_0030;
        bus.aux_wdata = 32'h5A5A_0000;
        for (int i = 0; i < 15; i++) begin
            ea = ((i % 5) == 4);
            settle();
            n_cmp++;
            if (bus.aux_gnt !== ea || bus.core_gnt !== !ea
                || bus.core_stall !== ea) begin
                n_err++;
                $display("FAIL starve_c%0d got=c%b a%b s%b exp=c%b a%b s%b",
                         i, bus.core_gnt, bus.aux_gnt, bus.core_stall,
                         !ea, ea, ea);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_aux_read();
        mem[8]       = 32'h1234_5678;
        mem[9]       = 32'h9ABC_DEF0;
        bus.aux_req  = 1'b1;
        bus.aux_we   = 1'b0;
        bus.aux_addr = 32'h0000_0020;
        settle();
        n_cmp++;
        if (bus.aux_gnt !== 1'b1 || bus.aux_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL aux_rd_gnt got=g%b v%b exp=g1 v0",
                     bus.aux_gnt, bus.aux_rvalid);
        end
        if (bus.aux_gnt === 1'b1) exp_q.push_back(mem[8]);
        step();
        bus.aux_req = 1'b0;
        settle();
        n_cmp++;
        if (bus.aux_rvalid !== 1'b1 || exp_q.size() == 0) begin
            n_err++;
            $display("FAIL aux_rvalid got=%b exp=1", bus.aux_rvalid);
        end else begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (bus.aux_rdata !== exp_v) begin
                n_err++;
                $display("FAIL aux_rdata got=%h exp=%h",
                         bus.aux_rdata, exp_v);
            end
        end
        step();
        settle();
        n_cmp++;
        if (bus.aux_rvalid !== 1'b0 || bus.aux_rdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL aux_rv_once got=v%b d%h exp=v0 d12345678",
                     bus.aux_rvalid, bus.aux_rdata);
        end
        step();
        // two reads back to back
        for (int i = 0; i < 4; i++) begin
            bus.aux_req  = (i < 2);
            bus.aux_addr = 32'h0000_0020 + 32'(i * 4);
            settle();
            if (i >= 1 && i <= 2) begin
                n_cmp++;
                if (bus.aux_rvalid !== 1'b1 || exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_rvalid%0d got=%b exp=1",
                             i, bus.aux_rvalid);
                end else begin
                    exp_v = exp_q.pop_front();
                    n_cmp++;
                    if (bus.aux_rdata !== exp_v) begin
                        n_err++;
                        $display("FAIL b2b_rdata%0d got=%h exp=%h",
                                 i, bus.aux_rdata, exp_v);
                    end
                end
            end
            if (i < 2) begin
                n_cmp++;
                if (bus.aux_gnt !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_gnt%0d got=%b exp=1", i, bus.aux_gnt);
                end
                exp_q.push_back(mem[8 + i]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_lock_burst();
        int   k;
        logic ea;
        k = 0;
        bus.core_req  = 1'b1;
        bus.core_we   = 1'b0;
        bus.core_addr = 32'h0000_0010;
        for (int i = 0; i < 8; i++) begin
            bus.aux_req   = (k < 3);
            bus.aux_we    = 1'b1;
            bus.aux_lock  = (k < 2);
            bus.aux_addr  = 32'(k * 4);
            bus.aux_wdata = 32'hA000_0000 + 32'(k);
            ea = (i >= 4 && i <= 6);
            settle();
            n_cmp++;
            if (bus.aux_gnt !== ea || bus.core_gnt !== !ea
                || bus.core_stall !== ea) begin
                n_err++;
                $display("FAIL lock_c%0d got=c%b a%b s%b exp=c%b a%b s%b",
                         i, bus.core_gnt, bus.aux_gnt, bus.core_stall,
                         !ea, ea, ea);
            end
            if (bus.aux_gnt === 1'b1) k++;
            step();
        end
        idle_inputs();
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (mem[j] !== 32'hA000_0000 + 32'(j)) begin
                n_err++;
                $display("FAIL lock_mem%0d got=%h exp=%h",
                         j, mem[j], 32'hA000_0000 + 32'(j));
            end
        end
        step();
    endtask

    task automatic test_reset_in_lock();
        bus.aux_req   = 1'b1;
        bus.aux_we    = 1'b1;
        bus.aux_lock  = 1'b1;
        bus.aux_addr  = 32'h0000_0040;
        bus.aux_wdata = 32'h0000_0011;
        settle();
        n_cmp++;
        if (bus.aux_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rl_first got=%b exp=1", bus.aux_gnt);
        end
        step();
        reset         = 1'b1;
        bus.core_req  = 1'b1;
        bus.aux_addr  = 32'h0000_0044;
        bus.aux_wdata = 32'h0000_0022;
        settle();
        n_cmp++;
        if (bus.aux_gnt !== 1'b0 || bus.core_gnt !== 1'b0
            || bus.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL rl_in_rst got=a%b c%b we%b exp=0 0 0",
                     bus.aux_gnt, bus.core_gnt, bus.mem_we);
        end
        step();
        n_cmp++;
        if (mem[16] !== 32'h11 || mem[17] !== 32'h0) begin
            n_err++;
            $display("FAIL rl_mem got=%h/%h exp=11/0", mem[16], mem[17]);
        end
        reset         = 1'b0;
        bus.aux_lock  = 1'b0;
        bus.aux_addr  = 32'h0000_0048;
        bus.aux_wdata = 32'h0000_0033;
        settle();
        n_cmp++;
        if (bus.core_gnt !== 1'b1 || bus.aux_gnt !== 1'b0
            || bus.aux_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rl_after got=c%b a%b v%b exp=c1 a0 v0",
                     bus.core_gnt, bus.aux_gnt, bus.aux_rvalid);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        idle_inputs();
        test_reset();
        test_core_only();
        test_starvation();
        test_aux_read();
        test_lock_burst();
        test_reset_in_lock();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
